cnn_layer_sequencer: RTL and testbench

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

---
 rtl/cnn_layer_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer
//
// Walks a sliding FILxFIL window across an IMGxIMG image in raster order and
// issues one operation per window position to a downstream datapath. After the
// last window it waits PIPE cycles for the datapath to drain, pulses done, and
// returns to idle.
//
// Parameters
//   IMG   image side length in pixels
//   FIL   filter side length
//   M_AW  image / result memory address width
//   F_AW  filter memory address width
//   PIPE  datapath latency from issue to write-back (cycles)
//
// Ports
//   clock      system clock
//   reset      synchronous active-high reset
//   start      one-cycle request to run a layer (accepted only in idle)
//   func_sel   operation code: 0 conv, 1 relu, 2 pool, 3 reserved (ignored)
//   fil_base   filter memory address for the layer
//   out_base   result base address for the layer
//   stall      memory busy; no window is issued while high
//   busy       layer in progress (run, drain, finish)
//   done       one-cycle completion pulse
//   op_valid   issue strobe for the current window
//   src1       image address of the window's top-left pixel
//   src2       filter address
//   dest       result write address
//   func       operation code applied to the issued window
//   issue_cnt  windows issued in the current layer
// -----------------------------------------------------------------------------
module cnn_layer_sequencer #(
    parameter int IMG  = 28,
    parameter int FIL  = 3,
    parameter int M_AW = 10,
    parameter int F_AW = 3,
    parameter int PIPE = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      func_sel,
    input  logic [F_AW-1:0] fil_base,
    input  logic [M_AW-1:0] out_base,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            op_valid,
    output logic [M_AW-1:0] src1,
    output logic [F_AW-1:0] src2,
    output logic [M_AW-1:0] dest,
    output logic [1:0]      func,
    output logic [M_AW-1:0] issue_cnt
);

    localparam int OUT = IMG - FIL + 1;
    localparam int RW  = $clog2(OUT + 1);
    localparam int DW  = (PIPE > 1) ? $clog2(PIPE) : 1;

    localparam logic [RW-1:0]   LAST_POS   = RW'(OUT - 1);
    localparam logic [M_AW-1:0] IMG_STEP   = M_AW'(IMG);
    localparam logic [M_AW-1:0] OUT_STEP   = M_AW'(OUT);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(PIPE - 1);
    localparam logic [1:0]      FUNC_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          state;

    // Window position within the output map.
    logic [RW-1:0]   row;
    logic [RW-1:0]   col;

    // Row base addresses kept incrementally: row*IMG and row*OUT.
    logic [M_AW-1:0] rbase_in;
    logic [M_AW-1:0] rbase_out;

    logic [DW-1:0]   drain_cnt;

    // Configuration captured when a layer is accepted.
    logic [1:0]      cfg_func;
    logic [F_AW-1:0] cfg_fil;
    logic [M_AW-1:0] cfg_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_valid  <= 1'b0;
            src1      <= '0;
            src2      <= '0;
            dest      <= '0;
            func      <= '0;
            issue_cnt <= '0;
            row       <= '0;
            col       <= '0;
            rbase_in  <= '0;
            rbase_out <= '0;
            drain_cnt <= '0;
            cfg_func  <= '0;
            cfg_fil   <= '0;
            cfg_out   <= '0;
        end else begin
            // Strobes default low; only the issuing / finishing paths raise them.
            op_valid <= 1'b0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && func_sel != FUNC_RSVD) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cfg_func  <= func_sel;
                        cfg_fil   <= fil_base;
                        cfg_out   <= out_base;
                        row       <= '0;
                        col       <= '0;
                        rbase_in  <= '0;
                        rbase_out <= '0;
                        issue_cnt <= '0;
                    end
                end

                RUN: begin
                    if (!stall) begin
                        op_valid  <= 1'b1;
                        src1      <= rbase_in + M_AW'(col);
                        dest      <= cfg_out + rbase_out + M_AW'(col);
                        src2      <= cfg_fil;
                        func      <= cfg_func;
                        issue_cnt <= issue_cnt + 1'b1;

                        if (col == LAST_POS) begin
                            col       <= '0;
                            row       <= row + 1'b1;
                            rbase_in  <= rbase_in + IMG_STEP;
                            rbase_out <= rbase_out + OUT_STEP;
                            if (row == LAST_POS) begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    // Drain length is fixed by datapath latency, independent of stall.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_sequencer
//
// Directed testbench for cnn_layer_sequencer with default parameters
// (IMG=28, FIL=3, OUT=26, 676 windows per layer, PIPE=3).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cnn_layer_sequencer;

    localparam int IMG  = 28;
    localparam int FIL  = 3;
    localparam int M_AW = 10;
    localparam int F_AW = 3;
    localparam int PIPE = 3;
    localparam int OUT  = 26;
    localparam int NWIN = 676;
    localparam int MAXC = 2000;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      func_sel;
    logic [F_AW-1:0] fil_base;
    logic [M_AW-1:0] out_base;
    logic            stall;
    logic            busy;
    logic            done;
    logic            op_valid;
    logic [M_AW-1:0] src1;
    logic [F_AW-1:0] src2;
    logic [M_AW-1:0] dest;
    logic [1:0]      func;
    logic [M_AW-1:0] issue_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    cnn_layer_sequencer #(
        .IMG (IMG),
        .FIL (FIL),
        .M_AW(M_AW),
        .F_AW(F_AW),
        .PIPE(PIPE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .func_sel (func_sel),
        .fil_base (fil_base),
        .out_base (out_base),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .op_valid (op_valid),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .func     (func),
        .issue_cnt(issue_cnt)
    );

    // Reference addresses for the k-th window (raster order).
    function automatic logic [M_AW-1:0] exp_src1(input int k);
        return M_AW'((k / OUT) * IMG + (k % OUT));
    endfunction

    function automatic logic [M_AW-1:0] exp_dest(input int ob, input int k);
        return M_AW'(ob + (k / OUT) * OUT + (k % OUT));
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] fs, input logic [F_AW-1:0] fb,
                               input logic [M_AW-1:0] ob);
        func_sel = fs;
        fil_base = fb;
        out_base = ob;
        start    = 1'b1;
        tick;
        start    = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        start    = 1'b1;
        stall    = 1'b1;
        func_sel = 2'd1;
        fil_base = 3'd5;
        out_base = 10'd9;
        tick;
        tick;
        checks++;
        if ({busy, done, op_valid, src1, src2, dest, func, issue_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b done=%0b op_valid=%0b src1=%0d src2=%0d dest=%0d func=%0d issue_cnt=%0d required all 0",
                     busy, done, op_valid, src1, src2, dest, func, issue_cnt);
        end
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_basic_conv;
        int k, s, last_s, done_s;
        k = 0; s = 0; last_s = -1; done_s = -1;
        // Start in the very first cycle after reset release.
        pulse_start(2'd0, 3'd2, 10'd0);
        checks++;
        if (busy !== 1'b1 || op_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_enter_run busy=%0b op_valid=%0b required 1 0", busy, op_valid);
        end
        for (int c = 0; c < MAXC && done_s < 0; c++) begin
            tick;
            s++;
            if (op_valid) begin
                checks++;
                if (src1 !== exp_src1(k) || dest !== exp_dest(0, k) || src2 !== 3'd2 || func !== 2'd0) begin
                    errors++;
                    $display("FAIL basic_issue k=%0d src1=%0d dest=%0d src2=%0d func=%0d required %0d %0d 2 0",
                             k, src1, dest, src2, func, exp_src1(k), exp_dest(0, k));
                end
                if (k == 0) begin
                    checks++;
                    if (src1 !== 10'd0 || dest !== 10'd0 || src2 !== 3'd2) begin
                        errors++;
                        $display("FAIL basic_first src1=%0d dest=%0d src2=%0d required 0 0 2", src1, dest, src2);
                    end
                end
                if (k == 1) begin
                    checks++;
                    if (src1 !== 10'd1) begin
                        errors++;
                        $display("FAIL basic_second src1=%0d required 1", src1);
                    end
                end
                if (k == 26) begin
                    checks++;
                    if (src1 !== 10'd28 || dest !== 10'd26) begin
                        errors++;
                        $display("FAIL basic_row1 src1=%0d dest=%0d required 28 26", src1, dest);
                    end
                end
                if (k == NWIN - 1) begin
                    checks++;
                    if (src1 !== 10'd725 || dest !== 10'd675) begin
                        errors++;
                        $display("FAIL basic_last src1=%0d dest=%0d required 725 675", src1, dest);
                    end
                end
                k++;
                last_s = s;
            end
            if (done) done_s = s;
        end
        checks++;
        if (done_s < 0) begin
            errors++;
            $display("FAIL basic_timeout done not seen within %0d cycles", MAXC);
        end
        checks++;
        if (k !== NWIN || issue_cnt !== 10'd676) begin
            errors++;
            $display("FAIL basic_count issues=%0d issue_cnt=%0d required 676 676", k, issue_cnt);
        end
        checks++;
        if (done_s - last_s !== PIPE || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_latency gap=%0d busy=%0b required %0d 1", done_s - last_s, busy, PIPE);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || issue_cnt !== 10'd676) begin
            errors++;
            $display("FAIL basic_after_done done=%0b busy=%0b issue_cnt=%0d required 0 0 676", done, busy, issue_cnt);
        end
    endtask

    task automatic test_stall;
        int k;
        logic seen_done;
        k = 0; seen_done = 1'b0;
        pulse_start(2'd0, 3'd1, 10'd0);
        for (int c = 0; c < MAXC && !seen_done; c++) begin
            tick;
            if (op_valid) begin
                checks++;
                if (src1 !== exp_src1(k) || dest !== exp_dest(0, k) || src2 !== 3'd1) begin
                    errors++;
                    $display("FAIL stall_issue k=%0d src1=%0d dest=%0d src2=%0d required %0d %0d 1",
                             k, src1, dest, src2, exp_src1(k), exp_dest(0, k));
                end
                if (k == 10) begin
                    checks++;
                    if (src1 !== 10'd10) begin
                        errors++;
                        $display("FAIL stall_resume src1=%0d required 10", src1);
                    end
                end
                k++;
                if (k == 10) begin
                    stall = 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        tick;
                        checks++;
                        if (op_valid !== 1'b0 || src1 !== 10'd9 || dest !== 10'd9 || src2 !== 3'd1 || issue_cnt !== 10'd10) begin
                            errors++;
                            $display("FAIL stall_hold cyc=%0d op_valid=%0b src1=%0d dest=%0d src2=%0d issue_cnt=%0d required 0 9 9 1 10",
                                     i, op_valid, src1, dest, src2, issue_cnt);
                        end
                    end
                    stall = 1'b0;
                end
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || k !== NWIN || issue_cnt !== 10'd676) begin
            errors++;
            $display("FAIL stall_total done=%0b issues=%0d issue_cnt=%0d required 1 676 676", seen_done, k, issue_cnt);
        end
        tick;
    endtask

    task automatic test_dest_wrap;
        int k;
        logic seen_done;
        k = 0; seen_done = 1'b0;
        pulse_start(2'd2, 3'd0, 10'd1000);
        for (int c = 0; c < MAXC && !seen_done; c++) begin
            tick;
            if (op_valid) begin
                checks++;
                if (dest !== exp_dest(1000, k) || src1 !== exp_src1(k) || func !== 2'd2) begin
                    errors++;
                    $display("FAIL wrap_issue k=%0d dest=%0d src1=%0d func=%0d required %0d %0d 2",
                             k, dest, src1, func, exp_dest(1000, k), exp_src1(k));
                end
                if (k == 0 || k == 23 || k == 24) begin
                    checks++;
                    if (dest !== ((k == 0) ? 10'd1000 : (k == 23) ? 10'd1023 : 10'd0)) begin
                        errors++;
                        $display("FAIL wrap_point k=%0d dest=%0d required %0d", k, dest,
                                 (k == 0) ? 1000 : (k == 23) ? 1023 : 0);
                    end
                end
                k++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || k !== NWIN || issue_cnt !== 10'd676) begin
            errors++;
            $display("FAIL wrap_total done=%0b issues=%0d issue_cnt=%0d required 1 676 676", seen_done, k, issue_cnt);
        end
        tick;
    endtask

    task automatic test_ignored_starts;
        int k;
        logic seen_done;
        k = 0; seen_done = 1'b0;
        pulse_start(2'd1, 3'd5, 10'd0);
        for (int c = 0; c < MAXC && !seen_done; c++) begin
            tick;
            start = 1'b0;
            if (op_valid) begin
                checks++;
                if (src1 !== exp_src1(k) || dest !== exp_dest(0, k) || src2 !== 3'd5 || func !== 2'd1) begin
                    errors++;
                    $display("FAIL ign_issue k=%0d src1=%0d dest=%0d src2=%0d func=%0d required %0d %0d 5 1",
                             k, src1, dest, src2, func, exp_src1(k), exp_dest(0, k));
                end
                k++;
                if (k == 50) begin
                    func_sel = 2'd2;
                    fil_base = 3'd7;
                    out_base = 10'd100;
                    start    = 1'b1;
                end
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || k !== NWIN || issue_cnt !== 10'd676) begin
            errors++;
            $display("FAIL ign_total done=%0b issues=%0d issue_cnt=%0d required 1 676 676", seen_done, k, issue_cnt);
        end
        // Start while in FIN must not relaunch the layer.
        func_sel = 2'd2;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || op_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ign_fin_start busy=%0b op_valid=%0b done=%0b required 0 0 0", busy, op_valid, done);
        end
        // Reserved opcode in idle is dropped.
        func_sel = 2'd3;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || op_valid !== 1'b0 || func !== 2'd1 || issue_cnt !== 10'd676) begin
            errors++;
            $display("FAIL ign_reserved busy=%0b op_valid=%0b func=%0d issue_cnt=%0d required 0 0 1 676",
                     busy, op_valid, func, issue_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        logic seen_done;
        k = 0; seen_done = 1'b0;
        pulse_start(2'd0, 3'd3, 10'd0);
        for (int c = 0; c < MAXC && k < 300; c++) begin
            tick;
            if (op_valid) k++;
        end
        checks++;
        if (k !== 300) begin
            errors++;
            $display("FAIL rmid_reach issues=%0d required 300", k);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if ({busy, done, op_valid, src1, src2, dest, func, issue_cnt} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs busy=%0b done=%0b op_valid=%0b src1=%0d src2=%0d dest=%0d func=%0d issue_cnt=%0d required all 0",
                     busy, done, op_valid, src1, src2, dest, func, issue_cnt);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || op_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_idle busy=%0b done=%0b op_valid=%0b required 0 0 0", busy, done, op_valid);
        end
        k = 0;
        pulse_start(2'd0, 3'd3, 10'd0);
        for (int c = 0; c < MAXC && !seen_done; c++) begin
            tick;
            if (op_valid) begin
                checks++;
                if (src1 !== exp_src1(k) || dest !== exp_dest(0, k)) begin
                    errors++;
                    $display("FAIL rmid_restart k=%0d src1=%0d dest=%0d required %0d %0d",
                             k, src1, dest, exp_src1(k), exp_dest(0, k));
                end
                k++;
            end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || k !== NWIN) begin
            errors++;
            $display("FAIL rmid_total done=%0b issues=%0d required 1 676", seen_done, k);
        end
        tick;
    endtask

    task automatic test_drain_stall;
        int k, s, last_s, done_s;
        k = 0; s = 0; last_s = -1; done_s = -1;
        pulse_start(2'd0, 3'd4, 10'd0);
        for (int c = 0; c < MAXC && done_s < 0; c++) begin
            tick;
            s++;
            if (op_valid) begin
                k++;
                if (k == NWIN) begin
                    stall  = 1'b1;
                    last_s = s;
                end
            end
            if (done) done_s = s;
        end
        stall = 1'b0;
        checks++;
        if (done_s < 0 || done_s - last_s !== PIPE) begin
            errors++;
            $display("FAIL drain_stall_latency done_at=%0d last_at=%0d gap=%0d required %0d",
                     done_s, last_s, done_s - last_s, PIPE);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL drain_stall_end busy=%0b done=%0b required 0 0", busy, done);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;
        func_sel = '0;
        fil_base = '0;
        out_base = '0;
        test_reset;
        test_basic_conv;
        test_stall;
        test_dest_wrap;
        test_ignored_starts;
        test_reset_mid;
        test_drain_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
